// File: rtl/memory_responder_pkg.sv
// Shared types and widths for the 16-bit memory bus responder.
package memory_responder_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned BUS_ADDR_W = 16;

    typedef struct packed {
        logic              valid;
        logic              oor;
        logic [DATA_W-1:0] word;
    } rd_entry_t;

endpackage

// File: rtl/mem_rd_pipe.sv
// Fixed-latency read return pipeline; the head entry owns the bus drive window.
module mem_rd_pipe
    import memory_responder_pkg::*;
#(
    parameter int unsigned LAT = 2
) (
    input  logic      clk,
    input  logic      flush,
    input  rd_entry_t in_entry,
    output rd_entry_t head
);

    rd_entry_t stage_q [LAT];
    rd_entry_t stage_d [LAT];

    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = in_entry;
        for (int unsigned k = 1; k < LAT; k++) begin
            stage_d[k] = stage_q[k-1];
        end
        if (flush) begin
            for (int unsigned k = 0; k < LAT; k++) begin
                stage_d[k] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        stage_q <= stage_d;
    end

    assign head = stage_q[LAT-1];

endmodule

// File: rtl/memory_responder.sv
// Memory target on the shared tri-state bus: synchronous writes, pipelined
// reads returned after RD_LATENCY edges, and saturating status counters.
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int unsigned     DEPTH      = 1024,
    parameter int unsigned     RD_LATENCY = 2,
    parameter logic [DATA_W-1:0] OOR_DATA = 16'hDEAD,
    parameter int unsigned     CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BUS_ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0]     data,
    input  logic                  rd,
    input  logic                  wr,
    output logic                  rd_valid,
    output logic [CNT_W-1:0]      rd_count,
    output logic [CNT_W-1:0]      wr_count,
    output logic [CNT_W-1:0]      err_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [AW-1:0]    idx_c;
    logic             oor_c;
    logic             rd_acc_c;
    logic             wr_acc_c;
    logic             mem_we_c;
    logic             drive_en_c;
    logic             err_evt_c;
    rd_entry_t        in_entry_c;
    rd_entry_t        head_c;

    logic [CNT_W-1:0] rd_count_q,  rd_count_d;
    logic [CNT_W-1:0] wr_count_q,  wr_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    always_comb begin
        idx_c      = addr[AW-1:0];
        oor_c      = (addr >> AW) != '0;
        rd_acc_c   = rd & ~wr;
        wr_acc_c   = wr & ~rd & ~oor_c;
        mem_we_c   = wr_acc_c & ~rst;
        // Contention with a tester write kills the returning entry.
        drive_en_c = head_c.valid & ~wr;
        err_evt_c  = ((rd | wr) & oor_c) | (rd & wr) | (head_c.valid & wr);

        in_entry_c       = '0;
        in_entry_c.valid = rd_acc_c;
        in_entry_c.oor   = oor_c;
        in_entry_c.word  = mem_q[idx_c];
    end

    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[idx_c] <= data;
        end
    end

    mem_rd_pipe #(
        .LAT (RD_LATENCY)
    ) u_rd_pipe (
        .clk      (clk),
        .flush    (rst),
        .in_entry (in_entry_c),
        .head     (head_c)
    );

    assign data     = drive_en_c ? (head_c.oor ? OOR_DATA : head_c.word) : {DATA_W{1'bz}};
    assign rd_valid = drive_en_c;

    // Saturating counters: hold once all ones.
    always_comb begin
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;
        err_count_d = err_count_q;
        if (rd_acc_c && (rd_count_q != '1)) begin
            rd_count_d = rd_count_q + CNT_W'(1);
        end
        if (wr_acc_c && (wr_count_q != '1)) begin
            wr_count_d = wr_count_q + CNT_W'(1);
        end
        if (err_evt_c && (err_count_q != '1)) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_q  <= '0;
            wr_count_q  <= '0;
            err_count_q <= '0;
        end else begin
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder with DEPTH=1024, RD_LATENCY=2.
module tb_memory_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic        tb_drv;
    logic [15:0] tb_data;
    wire  [15:0] data;
    logic        rd_valid;
    logic [15:0] rd_count;
    logic [15:0] wr_count;
    logic [15:0] err_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign data = tb_drv ? tb_data : 16'hzzzz;

    memory_responder #(
        .DEPTH      (1024),
        .RD_LATENCY (2),
        .OOR_DATA   (16'hDEAD),
        .CNT_W      (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .data      (data),
        .rd        (rd),
        .wr        (wr),
        .rd_valid  (rd_valid),
        .rd_count  (rd_count),
        .wr_count  (wr_count),
        .err_count (err_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Undriven bus reads as Z on 4-state simulators and 0 on 2-state ones.
    function automatic logic bus_idle();
        return (data === 16'hzzzz) || (data === 16'h0000);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_wr(input logic [15:0] a, input logic [15:0] d);
        addr = a; tb_data = d; tb_drv = 1'b1; wr = 1'b1;
        step();
        wr = 1'b0; tb_drv = 1'b0;
    endtask

    task automatic do_rd(input logic [15:0] a);
        addr = a; rd = 1'b1;
        step();
        rd = 1'b0;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic read_expect(input string tag, input logic [15:0] a, input logic [15:0] exp);
        do_rd(a);
        @(negedge clk);
        check({tag, "_pre_vld"}, rd_valid, 1'b0);
        check({tag, "_pre_idle"}, bus_idle(), 1'b1);
        @(negedge clk);
        check({tag, "_vld"}, rd_valid, 1'b1);
        check({tag, "_data"}, data, exp);
        @(negedge clk);
        check({tag, "_post_vld"}, rd_valid, 1'b0);
        check({tag, "_post_idle"}, bus_idle(), 1'b1);
    endtask

    initial begin
        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; tb_drv = 1'b0; tb_data = '0;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_vld", rd_valid, 1'b0);
        check("rst_idle", bus_idle(), 1'b1);
        check("rst_rdc", rd_count, 16'd0);
        check("rst_wrc", wr_count, 16'd0);
        check("rst_errc", err_count, 16'd0);

        // Single write then read with latency 2
        do_wr(16'h0010, 16'hA5A5);
        read_expect("basic", 16'h0010, 16'hA5A5);
        check("basic_rdc", rd_count, 16'd1);
        check("basic_wrc", wr_count, 16'd1);
        check("basic_errc", err_count, 16'd0);

        // Back-to-back reads return gapless and in order
        do_rst();
        for (int i = 0; i < 4; i++) do_wr(16'(i), 16'(i + 1));
        for (int j = 0; j < 7; j++) begin
            if (j < 4) begin
                rd = 1'b1; addr = 16'(j);
            end else begin
                rd = 1'b0;
            end
            @(negedge clk);
            if (j >= 2 && j <= 5) begin
                check("b2b_vld", rd_valid, 1'b1);
                check("b2b_data", data, 32'(j - 1));
            end else begin
                check("b2b_gap_vld", rd_valid, 1'b0);
            end
            step();
        end
        check("b2b_rdc", rd_count, 16'd4);
        check("b2b_wrc", wr_count, 16'd4);
        check("b2b_errc", err_count, 16'd0);

        // Out-of-range read and write; write must not alias into 0x3FF
        do_wr(16'h03FF, 16'h7777);
        do_rst();
        read_expect("oor_rd", 16'hFFFF, 16'hDEAD);
        do_wr(16'hFFFF, 16'h1234);
        read_expect("oor_alias", 16'h03FF, 16'h7777);
        check("oor_errc", err_count, 16'd2);
        check("oor_rdc", rd_count, 16'd2);
        check("oor_wrc", wr_count, 16'd0);

        // Collision: rd and wr together are both ignored
        do_wr(16'h0005, 16'h0505);
        addr = 16'h0005; tb_data = 16'hBEEF; tb_drv = 1'b1; rd = 1'b1; wr = 1'b1;
        step();
        rd = 1'b0; wr = 1'b0; tb_drv = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("coll_vld", rd_valid, 1'b0);
            check("coll_idle", bus_idle(), 1'b1);
        end
        check("coll_errc", err_count, 16'd3);
        read_expect("coll_mem", 16'h0005, 16'h0505);
        check("coll_rdc", rd_count, 16'd3);
        check("coll_wrc", wr_count, 16'd1);

        // Contention: tester writes during the drive window
        do_rd(16'h0010);
        step();
        addr = 16'h0020; tb_data = 16'h4242; tb_drv = 1'b1; wr = 1'b1;
        @(negedge clk);
        check("cont_data", data, 16'h4242);
        check("cont_vld", rd_valid, 1'b0);
        step();
        wr = 1'b0; tb_drv = 1'b0;
        @(negedge clk);
        check("cont_after_vld", rd_valid, 1'b0);
        check("cont_after_idle", bus_idle(), 1'b1);
        check("cont_errc", err_count, 16'd4);
        check("cont_wrc", wr_count, 16'd2);
        check("cont_rdc", rd_count, 16'd4);
        read_expect("cont_wr", 16'h0020, 16'h4242);

        // Reset while a read is in flight drops it; storage survives
        do_wr(16'h0030, 16'h3C3C);
        do_rd(16'h0030);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("rstf_vld", rd_valid, 1'b0);
            check("rstf_idle", bus_idle(), 1'b1);
        end
        check("rstf_rdc", rd_count, 16'd0);
        check("rstf_wrc", wr_count, 16'd0);
        check("rstf_errc", err_count, 16'd0);
        read_expect("rstf_mem", 16'h0030, 16'h3C3C);
        read_expect("rstf_old", 16'h0010, 16'hA5A5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
